// File: rtl/demux1_2_fifo_pkg.sv
// Shared constants and types for the 1:2 receive-side demux and its lane FIFOs.
// Lane indices match the encoding used by the 2:1 mux on the transmit side.
package demux1_2_fifo_pkg;

  localparam int DEMUX_WIDTH_DEF = 2;
  localparam int DEMUX_DEPTH_DEF = 2;
  localparam int DEMUX_CNT_W_DEF = 8;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  typedef enum logic [1:0] {
    LANE_EMPTY   = 2'd0,
    LANE_PARTIAL = 2'd1,
    LANE_FULL    = 2'd2
  } lane_state_e;

endpackage

// File: rtl/demux1_2_fifo_lane_fifo.sv
// Single-lane synchronous FIFO. The head word is presented registered and
// forced to zero while the lane is empty.
module lane_fifo
  import demux1_2_fifo_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH_DEF,
  parameter int DEPTH = DEMUX_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  lane_state_e      state;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    state = LANE_PARTIAL;
    if (occ == '0)
      state = LANE_EMPTY;
    else if (occ == (AW+1)'(DEPTH))
      state = LANE_FULL;
  end

  assign full    = (state == LANE_FULL);
  assign empty   = (state == LANE_EMPTY);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: reads are masked while the lane is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/demux1_2_fifo.sv
// Registered 1:2 demux: steers one valid/ready stream into two lane FIFOs
// and counts the words accepted per lane.
module demux1_2_fifo
  import demux1_2_fifo_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH_DEF,
  parameter int DEPTH = DEMUX_DEPTH_DEF,
  parameter int CNT_W = DEMUX_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  input  logic             selector,
  output logic             ready_in,
  output logic [WIDTH-1:0] data_out0,
  output logic             valid_out0,
  input  logic             ready_out0,
  output logic [WIDTH-1:0] data_out1,
  output logic             valid_out1,
  input  logic             ready_out1,
  output logic [CNT_W-1:0] count0,
  output logic [CNT_W-1:0] count1
);

  logic full0, full1;
  logic empty0, empty1;
  logic push0, push1;
  logic pop0, pop1;

  // No full-bypass: a full lane refuses input even if it pops this cycle.
  assign ready_in = (selector == LANE1) ? ~full1 : ~full0;

  assign push0 = valid_in & ready_in & (selector == LANE0);
  assign push1 = valid_in & ready_in & (selector == LANE1);

  assign valid_out0 = ~empty0;
  assign valid_out1 = ~empty1;
  assign pop0       = valid_out0 & ready_out0;
  assign pop1       = valid_out1 & ready_out1;

  lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane0 (
    .clk       (clk),
    .reset     (reset),
    .push      (push0),
    .push_data (data_in),
    .pop       (pop0),
    .pop_data  (data_out0),
    .full      (full0),
    .empty     (empty0)
  );

  lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane1 (
    .clk       (clk),
    .reset     (reset),
    .push      (push1),
    .push_data (data_in),
    .pop       (pop1),
    .pop_data  (data_out1),
    .full      (full1),
    .empty     (empty1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      count0 <= '0;
      count1 <= '0;
    end else begin
      if (push0) count0 <= count0 + CNT_W'(1);
      if (push1) count1 <= count1 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_demux1_2_fifo.sv
// Directed bench for demux1_2_fifo: per-lane expected-data queues are filled
// by the stimulus and drained by a monitor whenever a lane pops.
module tb_demux1_2_fifo;

  logic       clk;
  logic       reset;
  logic [1:0] data_in;
  logic       valid_in;
  logic       selector;
  logic       ready_in;
  logic [1:0] data_out0;
  logic       valid_out0;
  logic       ready_out0;
  logic [1:0] data_out1;
  logic       valid_out1;
  logic       ready_out1;
  logic [7:0] count0;
  logic [7:0] count1;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [1:0] q0[$];
  logic [1:0] q1[$];

  demux1_2_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .selector   (selector),
    .ready_in   (ready_in),
    .data_out0  (data_out0),
    .valid_out0 (valid_out0),
    .ready_out0 (ready_out0),
    .data_out1  (data_out1),
    .valid_out1 (valid_out1),
    .ready_out1 (ready_out1),
    .count0     (count0),
    .count1     (count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: inputs change just after posedge, so the negedge sees what the
  // next posedge will act on.
  always @(negedge clk) begin
    if (!reset) begin
      if (valid_out0 && ready_out0) begin
        if (q0.size() == 0) chk("lane0 unexpected pop", 1, 0);
        else chk("lane0 pop data", int'(data_out0), int'(q0.pop_front()));
      end
      if (valid_out1 && ready_out1) begin
        if (q1.size() == 0) chk("lane1 unexpected pop", 1, 0);
        else chk("lane1 pop data", int'(data_out1), int'(q1.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b1; valid_in = 1'b1; selector = 1'b0; data_in = 2'b11;
    ready_out0 = 1'b0; ready_out1 = 1'b0;

    // 1. reset held two cycles with a push requested
    tick(); tick();
    chk("rst valid_out0", int'(valid_out0), 0);
    chk("rst valid_out1", int'(valid_out1), 0);
    chk("rst data_out0", int'(data_out0), 0);
    chk("rst data_out1", int'(data_out1), 0);
    chk("rst count0", int'(count0), 0);
    chk("rst count1", int'(count1), 0);
    chk("rst ready_in", int'(ready_in), 1);
    reset = 1'b0; valid_in = 1'b0;
    tick();
    chk("post-rst valid_out0", int'(valid_out0), 0);

    // 2. steering and one-cycle latency
    data_in = 2'b01; selector = 1'b0; valid_in = 1'b1; q0.push_back(2'b01);
    tick();
    valid_in = 1'b0;
    chk("steer valid_out0", int'(valid_out0), 1);
    chk("steer data_out0", int'(data_out0), 1);
    chk("steer valid_out1 idle", int'(valid_out1), 0);
    chk("steer count0", int'(count0), 1);
    data_in = 2'b10; selector = 1'b1; valid_in = 1'b1; q1.push_back(2'b10);
    tick();
    valid_in = 1'b0;
    chk("steer valid_out1", int'(valid_out1), 1);
    chk("steer data_out1", int'(data_out1), 2);
    chk("steer count1", int'(count1), 1);
    chk("steer count0 held", int'(count0), 1);
    ready_out0 = 1'b1; ready_out1 = 1'b1;
    tick();
    ready_out0 = 1'b0; ready_out1 = 1'b0;
    chk("drain valid_out0", int'(valid_out0), 0);
    chk("drain data_out1 zero", int'(data_out1), 0);

    // 3. fill lane 0 and check backpressure
    data_in = 2'b11; selector = 1'b0; valid_in = 1'b1; q0.push_back(2'b11);
    tick();
    data_in = 2'b10; q0.push_back(2'b10);
    tick();
    data_in = 2'b01;
    #1 chk("full ready_in sel0", int'(ready_in), 0);
    tick();
    chk("full refused count0", int'(count0), 3);
    selector = 1'b1; valid_in = 1'b0;
    #1 chk("full ready_in sel1", int'(ready_in), 1);
    selector = 1'b0; valid_in = 1'b1; ready_out0 = 1'b1;
    #1 chk("no full bypass", int'(ready_in), 0);
    tick();
    valid_in = 1'b0; ready_out0 = 1'b0;
    chk("after pop data_out0", int'(data_out0), 2);
    chk("after pop count0", int'(count0), 3);
    #1 chk("after pop ready_in", int'(ready_in), 1);
    ready_out0 = 1'b1;
    tick();
    ready_out0 = 1'b0;
    chk("lane0 drained", int'(valid_out0), 0);

    // 4. simultaneous push/pop on one lane, then cross-lane independence
    data_in = 2'b01; selector = 1'b1; valid_in = 1'b1; q1.push_back(2'b01);
    tick();
    data_in = 2'b10; ready_out1 = 1'b1; q1.push_back(2'b10);
    tick();
    valid_in = 1'b0; ready_out1 = 1'b0;
    chk("pushpop valid_out1", int'(valid_out1), 1);
    chk("pushpop data_out1", int'(data_out1), 2);
    chk("pushpop count1", int'(count1), 3);
    data_in = 2'b11; selector = 1'b0; valid_in = 1'b1; ready_out1 = 1'b1; q0.push_back(2'b11);
    tick();
    valid_in = 1'b0; ready_out1 = 1'b0;
    chk("cross data_out0", int'(data_out0), 3);
    chk("cross valid_out1", int'(valid_out1), 0);
    chk("cross count0", int'(count0), 4);

    // 5. counter wrap from a clean reset, lane 0 popping continuously
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q0.delete(); q1.delete();
    selector = 1'b0; valid_in = 1'b1; ready_out0 = 1'b1;
    for (int i = 0; i < 255; i++) begin
      data_in = 2'(i);
      q0.push_back(2'(i));
      tick();
    end
    chk("wrap count0 255", int'(count0), 255);
    data_in = 2'b11; q0.push_back(2'b11);
    tick();
    valid_in = 1'b0;
    chk("wrap count0 0", int'(count0), 0);
    chk("wrap count1 0", int'(count1), 0);
    tick();
    ready_out0 = 1'b0;
    chk("wrap lane0 empty", int'(valid_out0), 0);

    // 6. reset with both lanes full and push/pop requested
    valid_in = 1'b1; selector = 1'b0;
    data_in = 2'b01; tick();
    data_in = 2'b10; tick();
    selector = 1'b1;
    data_in = 2'b11; tick();
    data_in = 2'b00; tick();
    #1 chk("both full ready_in", int'(ready_in), 0);
    reset = 1'b1; ready_out0 = 1'b1; selector = 1'b0; data_in = 2'b11;
    tick();
    reset = 1'b0; valid_in = 1'b0; ready_out0 = 1'b0;
    chk("mid-rst valid_out0", int'(valid_out0), 0);
    chk("mid-rst valid_out1", int'(valid_out1), 0);
    chk("mid-rst count0", int'(count0), 0);
    chk("mid-rst count1", int'(count1), 0);
    #1 chk("mid-rst ready_in", int'(ready_in), 1);
    data_in = 2'b10; selector = 1'b1; valid_in = 1'b1; q1.push_back(2'b10);
    tick();
    valid_in = 1'b0;
    chk("fresh data_out1", int'(data_out1), 2);
    chk("fresh valid_out0", int'(valid_out0), 0);
    chk("fresh count1", int'(count1), 1);
    ready_out1 = 1'b1;
    tick();
    ready_out1 = 1'b0;
    chk("fresh lane1 drained", int'(valid_out1), 0);

    tick();
    chk("lane0 queue drained", q0.size(), 0);
    chk("lane1 queue drained", q1.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/demux1_2_fifo.md
Name: demux1_2_fifo

Overview:
Registered 1:2 demultiplexer, the receive-side counterpart of the team's flopped 2:1 mux. One input word stream is steered by `selector` into one of two per-lane FIFOs. Each lane presents its data on an independent valid/ready output. The block sits after the mux stage in the datapath and splits the merged stream back into two lanes, with backpressure to the source.

Parameters:
- WIDTH, 2, bits per data word (matches the mux data width).
- DEPTH, 2, entries per lane FIFO; must be a power of two, 2 or more.
- CNT_W, 8, width of the per-lane accepted-word counters.

Ports:
- clk  in  1  single clock; everything is on the rising edge.
- reset  in  1  one clock; reset is synchronous and active-high.
- data_in  in  WIDTH  input word.
- valid_in  in  1  data_in is valid this cycle.
- selector  in  1  target lane: 0 selects lane 0, 1 selects lane 1. Sampled with data_in.
- ready_in  out  1  targeted lane can accept a word.
- data_out0  out  WIDTH  head of lane 0.
- valid_out0  out  1  lane 0 is non-empty.
- ready_out0  in  1  lane 0 consumer pops.
- data_out1  out  WIDTH  head of lane 1.
- valid_out1  out  1  lane 1 is non-empty.
- ready_out1  in  1  lane 1 consumer pops.
- count0  out  CNT_W  words accepted into lane 0; wraps.
- count1  out  CNT_W  words accepted into lane 1; wraps.

Behaviour:
- Reset, synchronous, while reset=1 at the clock edge:
  - both FIFOs empty; read and write pointers are 0;
  - count0 = count1 = 0;
  - valid_out0 = valid_out1 = 0;
  - data_out0 = data_out1 = 0.
  - Reset overrides any same-cycle push or pop. A reset mid-stream discards all stored words.
- ready_in is combinational: it equals NOT full of the lane chosen by the current selector. It does not depend on valid_in.
- Push: valid_in & ready_in at the edge writes data_in into the lane given by selector. The matching countN increments, wrapping from 2^CNT_W-1 to 0.
- If valid_in=1 and ready_in=0, the word is not taken. The source must hold data_in and selector until accepted. The block does not check this.
- Pop: valid_outN & ready_outN at the edge advances lane N's read pointer. ready_outN while valid_outN=0 is ignored.
- Latency: a word accepted at edge k appears on data_outN with valid_outN=1 after edge k, i.e. one cycle. There is no input-to-output combinational bypass.
- Output data: data_outN comes from the head-entry storage and is 0 whenever valid_outN=0. valid_outN = (occupancy of lane N != 0).
- Full lane: occupancy == DEPTH. ready_in for that lane is 0 even if the lane pops in the same cycle (no full-bypass).
- Empty lane with a push: occupancy goes 0 -> 1 and valid_outN rises next cycle.
- Push and pop on the same lane in the same cycle (not full, not empty): occupancy is unchanged and FIFO order is preserved.
- Push to lane A and pop from lane B in the same cycle: fully independent.
- Each lane has a log2(DEPTH)+1-bit occupancy counter. Pointers wrap modulo DEPTH.
- Per-lane FIFO order is strict. There is no ordering guarantee between the two lanes.
- No state machine beyond pointers and occupancy. Each lane is in one of three states: EMPTY, PARTIAL or FULL, derived from occupancy.

Decomposition:
- Shared package/include file holds:
  - DEMUX_WIDTH_DEF = 2, DEMUX_DEPTH_DEF = 2, DEMUX_CNT_W_DEF = 8;
  - lane index constants LANE0 = 1'b0 and LANE1 = 1'b1, shared with the mux side.
- One sub-module, `lane_fifo`, instantiated twice. It has parameters WIDTH and DEPTH, ports push/pop/data/full/empty, and is reset by the same synchronous reset.
- Counters and ready_in steering live in the top module.

Test Plan:
1. Reset check: hold reset=1 for 2 cycles with valid_in=1 -> valid_out0/1=0, data_out0/1=0, count0/1=0, ready_in=1.
2. Basic steering and latency: push 2'b01 with sel=0, then 2'b10 with sel=1, both ready_out=0.
   - Cycle after each push: the matching valid_outN=1.
   - data_out0=01, data_out1=10; count0=1, count1=1.
3. Full and backpressure: with DEPTH=2 and ready_out0=0, push 11 then 10 to lane 0.
   - ready_in=0 while sel=0; ready_in=1 when sel=1.
   - Raise ready_out0 for one cycle: data_out0 goes 11 -> 10 and ready_in returns to 1 the next cycle.
4. Simultaneous push and pop: with lane 1 holding one word 01, push 10 to lane 1 while popping.
   - Occupancy stays 1 and data_out1=10 next cycle.
   - A push to lane 0 while popping lane 1 updates both lanes independently.
5. Counter wrap: accept 256 words into lane 0 while continuously popping -> count0 wraps to 0 and count1 stays 0.
6. Reset mid-operation: both lanes full, assert reset for one cycle while a push and a pop are requested.
   - Next cycle: both lanes empty, counts 0, ready_in=1.
   - No stale data appears after a fresh push.
